banked_mem_rtl: RTL
===================

Name: banked_mem_rtl

Overview:
- Parametrised, word-addressed, banked memory with val/rdy request and response interfaces.
- Address is interleaved across banks: low bits select the bank, high bits select the word within the bank.
- Bank select comes from a generalised N-bit-to-one-hot decoder. This is the successor to the fixed 2-bit decoder.
- Sits between a processor/test-source and the memory arrays; one request accepted per cycle, read data returned one cycle later.

Parameters:
- p_num_banks, 4, number of banks; power of 2, >= 2
- p_words_per_bank, 16, words per bank; power of 2, >= 2
- p_data_nbits, 32, word width in bits

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_val  in  1  request valid
- req_rdy  out  1  request ready
- req_type  in  1  0 = read, 1 = write
- req_addr  in  log2(p_num_banks*p_words_per_bank)  word address
- req_wdata  in  p_data_nbits  write data
- resp_val  out  1  response valid
- resp_rdy  in  1  response ready
- resp_type  out  1  type of the request that produced this response
- resp_data  out  p_data_nbits  read data; 0 for write responses
- bank_sel  out  p_num_banks  registered one-hot bank of the last accepted request

Interface decision: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Address split: bank = req_addr[log2(p_num_banks)-1:0]; word index = remaining upper bits.
- Request fire: req_val && req_rdy. Response fire: resp_val && resp_rdy.
- Response path is a single-entry output register, flow-through. Ready rule: req_rdy = !resp_val || resp_rdy, so full throughput is kept under continuous resp_rdy.
- req_rdy must not depend on req_val.
- Read on request fire: at the clock edge, the selected bank's word is captured into the response register. resp_val = 1 the next cycle. Latency is exactly 1 cycle.
- Write on request fire: the selected bank's word is updated at the edge. Response generation for writes depends on BANKED_MEM_WR_RESP_EN (see Optional Feature).
- Read-after-write, same address, back-to-back cycles: the read returns the new data. The write happens at edge N; the read captures at edge N+1.
- Response stall: while resp_val && !resp_rdy, the response register holds resp_type and resp_data stable and req_rdy = 0.
- Simultaneous response fire and request fire: the register is reloaded with the new response. resp_val stays 1 with no bubble.
- bank_sel: on every request fire it loads the decoder output for that request's bank. Otherwise it holds.
- Reset values:
  - resp_val = 0, resp_type = 0, resp_data = 0, bank_sel = 0.
  - req_rdy = 1 in the cycle after reset deasserts.
- Memory arrays are not reset; reading before writing returns X. Benches must write first.
- Reset mid-operation: any pending response is dropped (resp_val = 0 next cycle). Writes that fired in the reset cycle are ignored. Array contents are unchanged.
- Wrap-around: the top address (all ones) maps to the last bank, last word. There is no out-of-range address, because the address width is exact.

Optional Feature:
- Macro: BANKED_MEM_WR_RESP_EN.
- Defined: every write produces a response with resp_type = 1 and resp_data = 0, under the same 1-cycle latency and stall rules as reads.
- Undefined:
  - Writes produce no response; resp_val is never set by a write.
  - A write fire with simultaneous response fire leaves resp_val = 0 next cycle.
  - A write is accepted whenever req_rdy = 1.

Decomposition:
- Shared package banked_mem_pkg:
  - constants REQ_READ = 1'b0 and REQ_WRITE = 1'b1
  - typedef for the request type
  - function computing the bank/index widths from parameters
- Sub-module decoder_nb_rtl: parameter p_nbits; in [p_nbits-1:0], out [2**p_nbits-1:0]; one-hot, purely combinational. Instantiated once for bank selection and tested standalone exhaustively for p_nbits = 1..4.
- Bank arrays: generate loop, one array per bank, write enable = decoder output && request fire && write.

Test Plan:
- Reset, then idle: resp_val = 0, bank_sel = 4'b0000, req_rdy = 1 in the first post-reset cycle.
- Write 0xdeadbeef to addr 5, then read addr 5 with resp_rdy = 1: resp_val = 1 one cycle after the read fire, resp_data = 0xdeadbeef, bank_sel = 4'b0010.
- Bank interleave: write values 0x10..0x13 to addrs 0..3, then read them back in order. Each readback matches; bank_sel steps 0001, 0010, 0100, 1000.
- Back-to-back stream: write addr 63 = 0xa5a5a5a5, then read addr 63 in the next cycle. resp_data = 0xa5a5a5a5 (last bank, last word); throughput is one per cycle.
- Stall: read addr 2 holding 0x22 with resp_rdy = 0 for 3 cycles. resp_data holds 0x22 and req_rdy = 0 throughout; after resp_rdy = 1 the next request is accepted the same cycle.
- Reset mid-operation: assert rst while resp_val = 1. Next cycle resp_val = 0; a subsequent read of a previously written address still returns its old data. With BANKED_MEM_WR_RESP_EN defined, a write gives resp_type = 1 and resp_data = 0.

Source files
------------

// File: rtl/banked_mem_pkg.sv
// banked_mem_pkg: request type constants and width helpers for the banked memory
package banked_mem_pkg;
  typedef logic req_type_t;
  localparam req_type_t REQ_READ = 1'b0;
  localparam req_type_t REQ_WRITE = 1'b1;
  function automatic int bank_nbits(int num_banks);
    return $clog2(num_banks);
  endfunction
  function automatic int idx_nbits(int words_per_bank);
    return $clog2(words_per_bank);
  endfunction
  function automatic int addr_nbits(int num_banks, int words_per_bank);
    return $clog2(num_banks * words_per_bank);
  endfunction
endpackage

// File: rtl/banked_mem_if.sv
// banked_mem_if: val/rdy request and response bus between source and banked memory
interface banked_mem_if
  import banked_mem_pkg::*;
#(
  parameter int p_num_banks = 4,
  parameter int p_words_per_bank = 16,
  parameter int p_data_nbits = 32
);
  localparam int c_addr_nbits = addr_nbits(p_num_banks, p_words_per_bank);
  logic req_val;
  logic req_rdy;
  req_type_t req_type;
  logic [c_addr_nbits-1:0] req_addr;
  logic [p_data_nbits-1:0] req_wdata;
  logic resp_val;
  logic resp_rdy;
  req_type_t resp_type;
  logic [p_data_nbits-1:0] resp_data;
  logic [p_num_banks-1:0] bank_sel;
  modport master (
    output req_val, req_type, req_addr, req_wdata, resp_rdy,
    input req_rdy, resp_val, resp_type, resp_data, bank_sel
  );
  modport slave (
    input req_val, req_type, req_addr, req_wdata, resp_rdy,
    output req_rdy, resp_val, resp_type, resp_data, bank_sel
  );
endinterface

// File: rtl/banked_mem_decoder.sv
// decoder_nb_rtl: combinational N-bit binary to one-hot decoder
module decoder_nb_rtl #(
  parameter int p_nbits = 2
) (
  input  logic [p_nbits-1:0] i_in,
  output logic [2**p_nbits-1:0] o_out
);
  always_comb begin
    o_out = '0;
    o_out[i_in] = 1'b1;
  end
endmodule

// File: rtl/banked_mem_rtl.sv
// banked_mem_rtl: interleaved banked memory, 1-cycle read latency; BANKED_MEM_WR_RESP_EN adds write responses
module banked_mem_rtl
  import banked_mem_pkg::*;
#(
  parameter int p_num_banks = 4,
  parameter int p_words_per_bank = 16,
  parameter int p_data_nbits = 32
) (
  input logic clk,
  input logic rst,
  banked_mem_if.slave bus
);
  localparam int c_bank_nbits = bank_nbits(p_num_banks);
  localparam int c_idx_nbits = idx_nbits(p_words_per_bank);
  localparam int c_addr_nbits = addr_nbits(p_num_banks, p_words_per_bank);
  logic [c_bank_nbits-1:0] w_bank;
  logic [c_idx_nbits-1:0] w_idx;
  logic [p_num_banks-1:0] w_dec;
  logic [p_data_nbits-1:0] w_rdata [p_num_banks];
  logic w_req_fire, w_resp_fire, w_wr_fire;
  logic r_resp_val;
  req_type_t r_resp_type;
  logic [p_data_nbits-1:0] r_resp_data;
  logic [p_num_banks-1:0] r_bank_sel;
  assign w_bank = bus.req_addr[c_bank_nbits-1:0];
  assign w_idx = bus.req_addr[c_addr_nbits-1:c_bank_nbits];
  assign bus.req_rdy = !r_resp_val || bus.resp_rdy;
  assign w_req_fire = bus.req_val && bus.req_rdy;
  assign w_resp_fire = r_resp_val && bus.resp_rdy;
  assign w_wr_fire = w_req_fire && (bus.req_type == REQ_WRITE) && !rst;
  decoder_nb_rtl #(.p_nbits(c_bank_nbits)) u_dec (.i_in(w_bank), .o_out(w_dec));
  for (genvar b = 0; b < p_num_banks; b++) begin : g_bank
    logic [p_data_nbits-1:0] r_mem [p_words_per_bank];
    always_ff @(posedge clk)
      if (w_wr_fire && w_dec[b]) r_mem[w_idx] <= bus.req_wdata;
    assign w_rdata[b] = r_mem[w_idx];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_val <= 1'b0;
      r_resp_type <= REQ_READ;
      r_resp_data <= '0;
      r_bank_sel <= '0;
    end else begin
      if (w_req_fire) r_bank_sel <= w_dec;
`ifdef BANKED_MEM_WR_RESP_EN
      if (w_req_fire) begin
        r_resp_val <= 1'b1;
        r_resp_type <= bus.req_type;
        r_resp_data <= (bus.req_type == REQ_WRITE) ? '0 : w_rdata[w_bank];
      end else if (w_resp_fire) r_resp_val <= 1'b0;
`else
      // a write can only fire while the register is empty or draining, so it just clears valid
      if (w_req_fire && bus.req_type == REQ_READ) begin
        r_resp_val <= 1'b1;
        r_resp_type <= REQ_READ;
        r_resp_data <= w_rdata[w_bank];
      end else if (w_resp_fire) r_resp_val <= 1'b0;
`endif
    end
  end
  assign bus.resp_val = r_resp_val;
  assign bus.resp_type = r_resp_type;
  assign bus.resp_data = r_resp_data;
  assign bus.bank_sel = r_bank_sel;
endmodule
